// File: rtl/status_serial_rx_pkg.sv
// Shared definitions for the status link receive path: receiver FSM
// encoding and the payload bit positions agreed with the transmitter.
package status_serial_rx_pkg;

  // Receiver states: waiting for a frame start, or collecting payload bits.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_t;

  // Payload bit positions; these must track the transmitter's message order.
  localparam int ARMED   = 0;
  localparam int ALARM   = 1;
  localparam int SENSOR1 = 2;
  localparam int SENSOR2 = 3;

endpackage

// File: rtl/status_serial_rx_confirm_filter.sv
// Debounce for received status frames: a payload must arrive CONFIRM times
// in a row, cleanly framed, before it replaces the exported status.
module status_confirm_filter
  import status_serial_rx_pkg::*;
#(
  parameter int MSG_W   = 4,
  parameter int CONFIRM = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [MSG_W-1:0] payload,
  input  logic             frame_done,
  input  logic             frame_bad,
  output logic [MSG_W-1:0] flags,
  output logic             status_valid
);

  localparam int              CONF_W   = $clog2(CONFIRM + 1);
  localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(CONFIRM);

  logic [MSG_W-1:0]  cand_q;
  logic [CONF_W-1:0] cnt_q;
  logic [MSG_W-1:0]  cand_next;
  logic [CONF_W-1:0] cnt_next;
  logic              load;

  // Next candidate and repeat count for the frame finishing this cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    cand_next = cand_q;
    cnt_next  = cnt_q;
    if (frame_done) begin
      if (frame_bad) begin
        cnt_next = '0;
      end else if (payload == cand_q) begin
        cnt_next = (cnt_q == CONF_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cand_next = payload;
        cnt_next  = CONF_W'(1);
      end
    end
  end

  // A confirmed candidate only matters when it actually changes the status.
  assign load = frame_done && !frame_bad && (cnt_next == CONF_MAX) && (cand_next != flags);

  // Candidate, count and exported status registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    if (!RST_N) begin
      cand_q       <= '0;
      cnt_q        <= '0;
      flags        <= '0;
      status_valid <= 1'b0;
    end else begin
      cand_q       <= cand_next;
      cnt_q        <= cnt_next;
      status_valid <= load;
      if (load) begin
        flags <= cand_next;
      end
    end
  end

endmodule

// File: rtl/status_serial_rx.sv
// Receive end of the 4-bit status link. Deserialises frames on the shared
// serial clock, polices framing and inter-frame gap, confirms repeated
// payloads and reports link health.
module status_serial_rx
  import status_serial_rx_pkg::*;
#(
  parameter int MSG_W        = 4,
  parameter int MIN_GAP      = 3,
  parameter int CONFIRM      = 2,
  parameter int LINK_TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic STATUS_IN,
  input  logic STATUS_SEND,
  output logic armed,
  output logic alarm,
  output logic sensor1,
  output logic sensor2,
  output logic status_valid,
  output logic frame_err,
  output logic link_ok
);

  localparam int SH_W  = MSG_W - 1;
  localparam int BIT_W = $clog2(MSG_W);
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam int TO_W  = $clog2(LINK_TIMEOUT + 1);

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(MSG_W - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_GAP);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(LINK_TIMEOUT);

  rx_state_t        state;
  logic [SH_W-1:0]  shift_q;     // bits 0..MSG_W-2; the last bit goes straight to the filter
  logic [BIT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             frame_bad_q;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_next;
  logic             seen_good_q;
  logic             frame_done;
  logic             good_done;
  logic [MSG_W-1:0] payload;
  logic [MSG_W-1:0] flags;

  // Frame completes on the edge that samples its last bit, unless a restart strobe overrides it.
  assign frame_done = (state == ST_SHIFT) && !STATUS_SEND && (bit_cnt == LAST_BIT);
  assign good_done  = frame_done && !frame_bad_q;
  assign payload    = {STATUS_IN, shift_q};

  // Receiver FSM: frame start detection, gap policing and bit collection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= GAP_MAX;   // first frame after reset is always legal
      frame_bad_q <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gap_cnt != GAP_MAX) begin
            gap_cnt <= gap_cnt + 1'b1;
          end
          if (STATUS_SEND) begin
            // A short gap is flagged but the frame is still received, just never used.
            frame_err   <= (gap_cnt < GAP_MAX);
            frame_bad_q <= (gap_cnt < GAP_MAX);
            shift_q     <= SH_W'(STATUS_IN);
            bit_cnt     <= BIT_W'(1);
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (STATUS_SEND) begin
            // Restart mid-frame: drop what was collected and treat this bit as a fresh bit0.
            frame_err   <= 1'b1;
            frame_bad_q <= 1'b0;
            shift_q     <= SH_W'(STATUS_IN);
            bit_cnt     <= BIT_W'(1);
          end else if (bit_cnt == LAST_BIT) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            shift_q[bit_cnt] <= STATUS_IN;
            bit_cnt          <= bit_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Good frames restart the silence timer; otherwise it counts up and saturates.
  always_comb begin
    if (good_done) begin
      to_next = '0;
    end else if (to_cnt == TO_MAX) begin
      to_next = to_cnt;
    end else begin
      to_next = to_cnt + 1'b1;
    end
  end

  // Link health: up once a good frame has been seen and the silence timer has not expired.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      to_cnt      <= '0;
      seen_good_q <= 1'b0;
      link_ok     <= 1'b0;
    end else begin
      to_cnt      <= to_next;
      seen_good_q <= seen_good_q | good_done;
      link_ok     <= (seen_good_q | good_done) && (to_next < TO_MAX);
    end
  end

  status_confirm_filter #(
    .MSG_W   (MSG_W),
    .CONFIRM (CONFIRM)
  ) u_confirm (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .payload      (payload),
    .frame_done   (frame_done),
    .frame_bad    (frame_bad_q),
    .flags        (flags),
    .status_valid (status_valid)
  );

  assign armed   = flags[ARMED];
  assign alarm   = flags[ALARM];
  assign sensor1 = flags[SENSOR1];
  assign sensor2 = flags[SENSOR2];

endmodule
